// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory load/store unit.
package dmem_pkg;

  // RV32I load/store funct3 encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Request/response sequencing states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for RV32I sub-word accesses: store byte enables and
// replicated write data, load lane extraction with sign/zero extension,
// and the misalignment / illegal-funct3 flag.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        bad_o
);

  logic        bad;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Decode access size, steer lanes and flag illegal/misaligned accesses
  always_comb begin
    bad     = 1'b0;
    be_o    = '0;
    wdata_o = '0;
    rdata_o = '0;
    lane_b  = 8'(rword_i >> {off_i, 3'b000});
    lane_h  = off_i[1] ? rword_i[31:16] : rword_i[15:0];
    if (we_i) begin
      case (funct3_i)
        F3_B: begin
          be_o    = 4'b0001 << off_i;
          wdata_o = {4{wdata_i[7:0]}};
        end
        F3_H: begin
          bad     = off_i[0];
          be_o    = off_i[1] ? 4'b1100 : 4'b0011;
          wdata_o = {2{wdata_i[15:0]}};
        end
        F3_W: begin
          bad     = (off_i != 2'b00);
          be_o    = 4'b1111;
          wdata_o = wdata_i;
        end
        default: bad = 1'b1;
      endcase
    end else begin
      case (funct3_i)
        F3_B:  rdata_o = {{24{lane_b[7]}}, lane_b};
        F3_BU: rdata_o = {24'h000000, lane_b};
        F3_H: begin
          bad     = off_i[0];
          rdata_o = {{16{lane_h[15]}}, lane_h};
        end
        F3_HU: begin
          bad     = off_i[0];
          rdata_o = {16'h0000, lane_h};
        end
        F3_W: begin
          bad     = (off_i != 2'b00);
          rdata_o = rword_i;
        end
        default: bad = 1'b1;
      endcase
    end
    if (bad) begin
      be_o    = '0;
      rdata_o = '0;
    end
    bad_o = bad;
  end

endmodule

// File: rtl/dmem_lsu.sv
// Word-organised data memory with RV32I sub-word access, valid/ready
// request and response handshakes and a configurable read latency.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = 3;
  localparam logic [CW-1:0] CNT_INIT = (LATENCY > 1) ? CW'(LATENCY - 2) : '0;

  logic [31:0]   mem_q [DEPTH];
  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          req_ready_q;
  logic          resp_valid_q;
  logic [31:0]   resp_rdata_q;
  logic          resp_err_q;

  logic [AW-1:0] widx;
  logic [31:0]   rword;
  logic [3:0]    be;
  logic [31:0]   wdata_sh;
  logic [31:0]   rdata_ext;
  logic          align_bad;
  logic          range_err;
  logic          err;
  logic          accept;

  assign widx      = req_addr[AW+1:2];
  assign rword     = mem_q[widx];
  // Full upper-address compare so high bits can never alias onto low words
  assign range_err = ({2'b00, req_addr[31:2]} >= 32'(DEPTH));
  assign err       = range_err | align_bad;
  assign accept    = req_valid & req_ready_q & ~rst;

  dmem_lane_align u_align (
    .we_i     (req_we),
    .funct3_i (req_funct3),
    .off_i    (req_addr[1:0]),
    .wdata_i  (req_wdata),
    .rword_i  (rword),
    .be_o     (be),
    .wdata_o  (wdata_sh),
    .rdata_o  (rdata_ext),
    .bad_o    (align_bad)
  );

  // Byte-enabled store commit at the accepting edge; array is never cleared
  always_ff @(posedge clk) begin
    if (accept && req_we && !err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem_q[widx][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

  // Handshake sequencer with registered response and ready outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            req_ready_q  <= 1'b0;
            resp_err_q   <= err;
            resp_rdata_q <= (req_we || err) ? '0 : rdata_ext;
            if (LATENCY == 1) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: one instance with LATENCY=1 driven from a
// vector table, one with LATENCY=3 for back-pressure and reset corner cases.
module tb_dmem_lsu;
  import dmem_pkg::*;

  logic        clk;
  logic        rst        [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [2:0]  req_funct3 [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  int total = 0;
  int bad   = 0;

  dmem_lsu #(.DEPTH(1024), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_funct3(req_funct3[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  dmem_lsu #(.DEPTH(1024), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_funct3(req_funct3[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rd, input logic er);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd; v.exp_rd = rd; v.exp_err = er;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // One complete transaction: drive, accept, wait (bounded) for response, consume
  task automatic txn(input int d, input logic we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, output logic [31:0] rd, output logic er,
                     output int lat);
    @(negedge clk);
    req_valid[d] = 1'b1; req_we[d] = we; req_funct3[d] = f3;
    req_addr[d] = a; req_wdata[d] = wd;
    @(posedge clk);
    #1 req_valid[d] = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (resp_valid[d]) begin
        lat = k;
        break;
      end
    end
    rd = resp_rdata[d];
    er = resp_err[d];
    resp_ready[d] = 1'b1;
    @(posedge clk);
    #1 resp_ready[d] = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          seen;

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_funct3[d] = 3'b000;
      req_addr[d] = '0; req_wdata[d] = '0; resp_ready[d] = 1'b0;
    end

    vecs.push_back(mk(1'b1, F3_W,  32'h0000_0004, 32'h0000_0000, 32'h0000_0000, 1'b0));
    vecs.push_back(mk(1'b1, F3_W,  32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0));
    vecs.push_back(mk(1'b0, F3_W,  32'h0000_0000, 32'h0,         32'hDEAD_BEEF, 1'b0));
    vecs.push_back(mk(1'b1, F3_B,  32'h0000_0005, 32'h1234_56AA, 32'h0000_0000, 1'b0));
    vecs.push_back(mk(1'b0, F3_B,  32'h0000_0005, 32'h0,         32'hFFFF_FFAA, 1'b0));
    vecs.push_back(mk(1'b0, F3_BU, 32'h0000_0005, 32'h0,         32'h0000_00AA, 1'b0));
    vecs.push_back(mk(1'b0, F3_W,  32'h0000_0004, 32'h0,         32'h0000_AA00, 1'b0));
    vecs.push_back(mk(1'b1, F3_H,  32'h0000_0006, 32'hFFFF_8001, 32'h0000_0000, 1'b0));
    vecs.push_back(mk(1'b0, F3_H,  32'h0000_0006, 32'h0,         32'hFFFF_8001, 1'b0));
    vecs.push_back(mk(1'b0, F3_HU, 32'h0000_0006, 32'h0,         32'h0000_8001, 1'b0));
    vecs.push_back(mk(1'b0, F3_H,  32'h0000_0005, 32'h0,         32'h0000_0000, 1'b1));
    vecs.push_back(mk(1'b0, F3_W,  32'h0000_0004, 32'h0,         32'h8001_AA00, 1'b0));
    vecs.push_back(mk(1'b1, F3_B,  32'h0000_0007, 32'h0000_005A, 32'h0000_0000, 1'b0));
    vecs.push_back(mk(1'b0, F3_BU, 32'h0000_0007, 32'h0,         32'h0000_005A, 1'b0));
    vecs.push_back(mk(1'b0, F3_H,  32'h0000_0004, 32'h0,         32'hFFFF_AA00, 1'b0));
    vecs.push_back(mk(1'b0, F3_W,  32'h0000_0004, 32'h0,         32'h5A01_AA00, 1'b0));
    vecs.push_back(mk(1'b1, F3_W,  32'h0000_0002, 32'h1111_1111, 32'h0000_0000, 1'b1));
    vecs.push_back(mk(1'b1, F3_H,  32'h0000_0001, 32'h2222_2222, 32'h0000_0000, 1'b1));
    vecs.push_back(mk(1'b1, F3_BU, 32'h0000_0000, 32'h3333_3333, 32'h0000_0000, 1'b1));
    vecs.push_back(mk(1'b0, F3_W,  32'h0000_0000, 32'h0,         32'hDEAD_BEEF, 1'b0));
    vecs.push_back(mk(1'b0, F3_HU, 32'h0000_0002, 32'h0,         32'h0000_DEAD, 1'b0));
    vecs.push_back(mk(1'b0, F3_B,  32'h0000_0003, 32'h0,         32'hFFFF_FFDE, 1'b0));
    vecs.push_back(mk(1'b0, F3_BU, 32'h0000_0000, 32'h0,         32'h0000_00EF, 1'b0));
    vecs.push_back(mk(1'b0, F3_W,  32'h0000_1000, 32'h0,         32'h0000_0000, 1'b1));
    vecs.push_back(mk(1'b0, F3_W,  32'h8000_0000, 32'h0,         32'h0000_0000, 1'b1));
    vecs.push_back(mk(1'b0, 3'b011, 32'h0000_0000, 32'h0,        32'h0000_0000, 1'b1));
    vecs.push_back(mk(1'b1, F3_W,  32'h0000_0FFC, 32'h1234_5678, 32'h0000_0000, 1'b0));
    vecs.push_back(mk(1'b0, F3_W,  32'h0000_0FFC, 32'h0,         32'h1234_5678, 1'b0));

    // Reset values while reset is held
    #2;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst%0d_req_ready", d), 32'(req_ready[d]), 32'd1);
      chk($sformatf("rst%0d_resp_valid", d), 32'(resp_valid[d]), 32'd0);
      chk($sformatf("rst%0d_resp_rdata", d), resp_rdata[d], 32'd0);
      chk($sformatf("rst%0d_resp_err", d), 32'(resp_err[d]), 32'd0);
    end
    @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;

    // Table-driven pass on the LATENCY=1 instance
    foreach (vecs[i]) begin
      txn(0, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, er, lat);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd1);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_ready_after", i), 32'(req_ready[0]), 32'd1);
    end

    // LATENCY=3: preload two words
    txn(1, 1'b1, F3_W, 32'h10, 32'hCAFE_F00D, rd, er, lat);
    chk("l3_store0_latency", 32'(lat), 32'd3);
    txn(1, 1'b1, F3_W, 32'h14, 32'h1357_2468, rd, er, lat);
    chk("l3_store1_latency", 32'(lat), 32'd3);

    // Back-pressured load; a competing store is presented but must be ignored
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_funct3[1] = F3_W; req_addr[1] = 32'h10;
    @(posedge clk);
    #1 req_we[1] = 1'b1; req_wdata[1] = 32'hBADB_AD00;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (resp_valid[1]) begin
        lat = k;
        break;
      end
    end
    chk("bp_latency", 32'(lat), 32'd3);
    for (int h = 0; h < 4; h++) begin
      chk($sformatf("bp_hold%0d_valid", h), 32'(resp_valid[1]), 32'd1);
      chk($sformatf("bp_hold%0d_ready", h), 32'(req_ready[1]), 32'd0);
      chk($sformatf("bp_hold%0d_rdata", h), resp_rdata[1], 32'hCAFE_F00D);
      @(negedge clk);
    end
    req_we[1] = 1'b0; req_addr[1] = 32'h14;
    resp_ready[1] = 1'b1;
    @(posedge clk);
    #1 resp_ready[1] = 1'b0;
    chk("bp_ready_after_hs", 32'(req_ready[1]), 32'd1);
    chk("bp_valid_after_hs", 32'(resp_valid[1]), 32'd0);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    chk("bp_next_accepted", 32'(req_ready[1]), 32'd0);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (resp_valid[1]) begin
        lat = k;
        break;
      end
    end
    chk("bp_next_latency", 32'(lat), 32'd3);
    chk("bp_next_rdata", resp_rdata[1], 32'h1357_2468);
    resp_ready[1] = 1'b1;
    @(posedge clk);
    #1 resp_ready[1] = 1'b0;
    txn(1, 1'b0, F3_W, 32'h10, 32'h0, rd, er, lat);
    chk("bp_ignored_store_rdata", rd, 32'hCAFE_F00D);

    // Reset while a store waits for its response
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_funct3[1] = F3_W;
    req_addr[1] = 32'h20; req_wdata[1] = 32'h7766_5544;
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    chk("mid_rst_busy", 32'(req_ready[1]), 32'd0);
    @(negedge clk);
    rst[1] = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(resp_valid[1]), 32'd0);
    chk("mid_rst_ready", 32'(req_ready[1]), 32'd1);
    chk("mid_rst_rdata", resp_rdata[1], 32'd0);
    chk("mid_rst_err", 32'(resp_err[1]), 32'd0);
    @(negedge clk);
    rst[1] = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (resp_valid[1]) seen++;
    end
    chk("mid_rst_no_resp", 32'(seen), 32'd0);
    txn(1, 1'b0, F3_W, 32'h20, 32'h0, rd, er, lat);
    chk("mid_rst_load_latency", 32'(lat), 32'd3);
    chk("mid_rst_load_rdata", rd, 32'h7766_5544);
    chk("mid_rst_load_err", 32'(er), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
